// File: rtl/bus_rsp_queue_pkg.sv
// Shared types for the bus response queue: bus message encoding, response entry layout.
package bus_rsp_queue_pkg;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    GET_S = 2'd1,
    GET_M = 2'd2,
    PUT_M = 2'd3
  } message_t;

  localparam int DCACHE_WORD_IN_BITS = 64;
  localparam int MEM_TAG_W_DFLT      = 4;

  typedef struct packed {
    logic                           id;
    logic [DCACHE_WORD_IN_BITS-1:0] data;
  } rsp_entry_t;

endpackage

// File: rtl/bus_rsp_queue_if.sv
// Bus-side and D-cache-controller-side signals of the response queue.
// The master modport is the bus/controller view; slave is the queue view.
interface bus_rsp_queue_if
  import bus_rsp_queue_pkg::*;
#(
  parameter int MEM_TAG_W = MEM_TAG_W_DFLT
) ();
  logic                           bus_req_ack_i;
  logic                           bus_req_id_i;
  message_t                       bus_req_message_i;
  logic [MEM_TAG_W-1:0]           mem2bus_response_i;
  logic [MEM_TAG_W-1:0]           mem2bus_tag_i;
  logic [DCACHE_WORD_IN_BITS-1:0] mem2bus_data_i;
  logic                           c2c_rsp_vld_i;
  logic [DCACHE_WORD_IN_BITS-1:0] c2c_rsp_data_i;
  logic                           bus2Dctrl_rsp_vld_o;
  logic                           bus2Dctrl_rsp_id_o;
  logic [DCACHE_WORD_IN_BITS-1:0] bus2Dctrl_rsp_data_o;
  logic [1:0]                     Dctrl2bus_rsp_ack_i;
  logic                           rspq_stall_o;
  logic                           rspq_err_o;

  modport master (
    output bus_req_ack_i, bus_req_id_i, bus_req_message_i, mem2bus_response_i,
    output mem2bus_tag_i, mem2bus_data_i, c2c_rsp_vld_i, c2c_rsp_data_i,
    output Dctrl2bus_rsp_ack_i,
    input  bus2Dctrl_rsp_vld_o, bus2Dctrl_rsp_id_o, bus2Dctrl_rsp_data_o,
    input  rspq_stall_o, rspq_err_o
  );

  modport slave (
    input  bus_req_ack_i, bus_req_id_i, bus_req_message_i, mem2bus_response_i,
    input  mem2bus_tag_i, mem2bus_data_i, c2c_rsp_vld_i, c2c_rsp_data_i,
    input  Dctrl2bus_rsp_ack_i,
    output bus2Dctrl_rsp_vld_o, bus2Dctrl_rsp_id_o, bus2Dctrl_rsp_data_o,
    output rspq_stall_o, rspq_err_o
  );
endinterface

// File: rtl/bus_rsp_queue_rspq_fifo.sv
// Two-write / one-read circular buffer. Port a is the older of two same-cycle writes;
// writes are packed so a lone port-b write lands at the current write pointer.
module rspq_fifo
  import bus_rsp_queue_pkg::*;
#(
  parameter int RSPQ_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_a_en,
  input  rsp_entry_t                  wr_a,
  input  logic                        wr_b_en,
  input  rsp_entry_t                  wr_b,
  input  logic                        rd_en,
  output rsp_entry_t                  rd_data,
  output logic [$clog2(RSPQ_DEPTH):0] count,
  output logic [$clog2(RSPQ_DEPTH):0] count_nxt
);
  localparam int AW = $clog2(RSPQ_DEPTH);

  rsp_entry_t    mem [RSPQ_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr, wr_ptr_b;
  logic [AW:0]   inc_a, inc_b, inc_r;

  assign inc_a     = {{AW{1'b0}}, wr_a_en};
  assign inc_b     = {{AW{1'b0}}, wr_b_en};
  assign inc_r     = {{AW{1'b0}}, rd_en};
  assign wr_ptr_b  = wr_ptr + inc_a;
  assign count     = wr_ptr - rd_ptr;
  assign count_nxt = count + inc_a + inc_b - inc_r;
  assign rd_data   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + inc_a + inc_b;
      rd_ptr <= rd_ptr + inc_r;
    end
  end

  // Storage carries no reset; occupancy is defined by the pointers alone.
  always_ff @(posedge clk) begin
    if (wr_a_en) mem[wr_ptr[AW-1:0]]   <= wr_a;
    if (wr_b_en) mem[wr_ptr_b[AW-1:0]] <= wr_b;
  end

endmodule

// File: rtl/bus_rsp_queue.sv
// Bus response queue: tracks granted GETs by memory tag and merges memory and
// cache-to-cache data into one in-order FIFO. Forwarding enabled by BUS_RSP_C2C_EN.
module bus_rsp_queue
  import bus_rsp_queue_pkg::*;
#(
  parameter int RSPQ_DEPTH = 8,
  parameter int MEM_TAG_W  = MEM_TAG_W_DFLT
) (
  input logic            clk,
  input logic            rst,
  bus_rsp_queue_if.slave bus
);
  localparam int              NTAG    = 1 << MEM_TAG_W;
  localparam int              CW      = $clog2(RSPQ_DEPTH) + 1;
  localparam logic [CW-1:0]   DEPTH_C = CW'(RSPQ_DEPTH);
  localparam logic [CW-1:0]   STALL_C = CW'(RSPQ_DEPTH - 2);

  logic [NTAG-1:0]      tag_vld, tag_vld_nxt, tag_id, tag_drop;
  logic                 err_q, stall_p1;
  logic [MEM_TAG_W-1:0] alloc_tag, ret_tag;
  logic                 grant_get, collide, alloc_ok, alloc_err;
  logic                 ret_en, ret_hit, ret_err;
  logic                 c2c_vld, push_a, push_b, acc_a, acc_b, ovf_err;
  logic                 vld, pop;
  rsp_entry_t           push_a_ent, push_b_ent, head;
  logic [CW-1:0]        count, count_nxt;

`ifdef BUS_RSP_C2C_EN
  assign c2c_vld = bus.c2c_rsp_vld_i;
`else
  logic unused_c2c;
  assign unused_c2c = bus.c2c_rsp_vld_i;
  assign c2c_vld    = 1'b0;
`endif

  assign alloc_tag = bus.mem2bus_response_i;
  assign ret_tag   = bus.mem2bus_tag_i;
  assign grant_get = bus.bus_req_ack_i &&
                     (bus.bus_req_message_i == GET_S || bus.bus_req_message_i == GET_M);

  // A return acts on the old entry first, so a same-tag alloc sees the slot as free.
  assign ret_en    = ret_tag != '0;
  assign ret_hit   = ret_en && tag_vld[ret_tag];
  assign ret_err   = ret_en && !tag_vld[ret_tag];
  assign collide   = grant_get && ret_en && (alloc_tag == ret_tag);
  assign alloc_ok  = grant_get && (alloc_tag != '0) && (!tag_vld[alloc_tag] || collide);
  assign alloc_err = grant_get && ((alloc_tag == '0) || (tag_vld[alloc_tag] && !collide));

  assign push_a     = alloc_ok && c2c_vld;
  assign push_a_ent = '{id: bus.bus_req_id_i, data: bus.c2c_rsp_data_i};
  assign push_b     = ret_hit && !tag_drop[ret_tag];
  assign push_b_ent = '{id: tag_id[ret_tag], data: bus.mem2bus_data_i};

  assign acc_a   = push_a && (count < DEPTH_C);
  assign acc_b   = push_b && ((count + CW'(acc_a)) < DEPTH_C);
  assign ovf_err = (push_a && !acc_a) || (push_b && !acc_b);

  assign vld = count != '0;
  assign pop = vld && bus.Dctrl2bus_rsp_ack_i[head.id];

  rspq_fifo #(.RSPQ_DEPTH(RSPQ_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_a_en   (acc_a),
    .wr_a      (push_a_ent),
    .wr_b_en   (acc_b),
    .wr_b      (push_b_ent),
    .rd_en     (pop),
    .rd_data   (head),
    .count     (count),
    .count_nxt (count_nxt)
  );

  always_comb begin
    tag_vld_nxt = tag_vld;
    if (ret_hit)  tag_vld_nxt[ret_tag]   = 1'b0;
    if (alloc_ok) tag_vld_nxt[alloc_tag] = 1'b1;
  end

  // Tag 0 is never allocated, so table-full means every tag from 1 upward is in use.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tag_vld  <= '0;
      err_q    <= 1'b0;
      stall_p1 <= 1'b0;
    end else begin
      tag_vld  <= tag_vld_nxt;
      err_q    <= err_q | alloc_err | ret_err | collide | ovf_err;
      stall_p1 <= (count_nxt >= STALL_C) || (&tag_vld_nxt[NTAG-1:1]);
    end
  end

  always_ff @(posedge clk) begin
    if (alloc_ok) begin
      tag_id[alloc_tag]   <= bus.bus_req_id_i;
      tag_drop[alloc_tag] <= c2c_vld;
    end
  end

  assign bus.bus2Dctrl_rsp_vld_o  = vld;
  assign bus.bus2Dctrl_rsp_id_o   = vld & head.id;
  assign bus.bus2Dctrl_rsp_data_o = vld ? head.data : '0;
  assign bus.rspq_stall_o         = stall_p1;
  assign bus.rspq_err_o           = err_q;

endmodule

// File: doc/bus_rsp_queue.md
Name: bus_rsp_queue

Overview:
Response-side stage of the snooping bus, directly upstream of each core's D-cache controller.
- Records every granted GET_S/GET_M against the memory tag returned for it.
- Merges memory data and cache-to-cache data into one in-order response FIFO.
- Presents the FIFO head to both controllers as {vld, id, data}; pops when the addressed core acks.
- Back-pressures the bus arbiter when the FIFO or the tag table cannot take more traffic.

Parameters:
RSPQ_DEPTH, 8, response FIFO entries (power of 2, >= 4)
MEM_TAG_W, 4, memory transaction tag width; tag 0 means "not accepted"

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
bus_req_ack_i  in  1  bus grant this cycle
bus_req_id_i  in  1  requesting CPU id
bus_req_message_i  in  message_t  granted message (GET_S, GET_M, PUT_M, NONE)
mem2bus_response_i  in  MEM_TAG_W  tag the memory assigned to this cycle's request
mem2bus_tag_i  in  MEM_TAG_W  tag of returning memory data, 0 = none
mem2bus_data_i  in  64  returning memory data
c2c_rsp_vld_i  in  1  snooping cache supplies the line this cycle
c2c_rsp_data_i  in  64  cache-to-cache data
bus2Dctrl_rsp_vld_o  out  1  FIFO head valid
bus2Dctrl_rsp_id_o  out  1  destination CPU of the head entry
bus2Dctrl_rsp_data_o  out  64  head data
Dctrl2bus_rsp_ack_i  in  2  per-CPU pop ack (bit n from CPU n)
rspq_stall_o  out  1  arbiter must not grant GET_S/GET_M
rspq_err_o  out  1  sticky protocol error

Behaviour:
- Reset (rst==0 at a clk edge):
  - FIFO empty; tag table all invalid.
  - All outputs 0; rspq_err_o cleared.
  - Entries in flight are discarded, including ones mid-handshake.
- Tag table: 2^MEM_TAG_W entries {valid, id, drop}.
  - Allocate: bus_req_ack_i && message in {GET_S, GET_M} && mem2bus_response_i != 0. Write entry[mem2bus_response_i] = {1, bus_req_id_i, drop}.
  - drop = c2c_rsp_vld_i, or 0 when forwarding is compiled out.
  - Allocating an already-valid tag, or a grant with mem2bus_response_i == 0: set rspq_err_o and skip the allocation.
  - PUT_M and NONE never allocate and never push.
- Memory return (mem2bus_tag_i != 0):
  - Valid entry: clear it. Push {id, mem2bus_data_i} unless drop == 1.
  - Invalid entry: set rspq_err_o, no push.
- Cache-to-cache: a c2c_rsp_vld_i cycle with an allocating grant pushes {bus_req_id_i, c2c_rsp_data_i} in that same cycle.
- Push ordering: up to 2 pushes per cycle; the c2c push occupies the older slot. Data appears at the head the next cycle, so push-to-vld latency is 1.
- Pop: bus2Dctrl_rsp_vld_o && Dctrl2bus_rsp_ack_i[bus2Dctrl_rsp_id_o].
  - Ack from the other CPU is ignored.
  - Head outputs hold stable until popped.
  - Pop and push in the same cycle are both legal; count updates by pushes minus pop.
- Occupancy:
  - rspq_stall_o = (count >= RSPQ_DEPTH-2) | (all tag entries valid), registered from next-state count.
  - Guarantees no overflow, since a granted cycle plus a concurrent return push at most 2.
  - A push into a full FIFO (arbiter violation) is dropped and sets rspq_err_o.
- Pointers: MEM_TAG_W-independent, log2(RSPQ_DEPTH)+1 bits, wrap naturally.
- Same-cycle alloc and return of the same tag cannot legally occur. If it does, the return acts on the old entry, the alloc writes the new entry, and rspq_err_o is set.

Optional Feature:
BUS_RSP_C2C_EN
- Defined: cache-to-cache forwarding as above; memory data for drop entries is discarded.
- Undefined: c2c_rsp_vld_i/c2c_rsp_data_i are ignored, drop is always 0, and every granted GET returns memory data only.

Decomposition:
- Shared package: message_t enum (NONE, GET_S, GET_M, PUT_M), DCACHE_WORD_IN_BITS, MEM_TAG_W default, and rsp_entry_t struct {id, data}.
- One sub-module, rspq_fifo: 2-write/1-read circular buffer with count output.
- Tag table and error logic stay in the top module.

Test Plan:
- Grant GET_S, id=1, response tag 3; memory returns tag 3 with data 0xDEAD_BEEF two cycles later -> next cycle vld=1, id=1, data=0xDEADBEEF. ack[0] leaves the entry in place; ack[1] empties the FIFO.
- C2C (feature on): grant GET_S id=0, tag 5, c2c_rsp_vld_i with data 0x1234 -> head {0, 0x1234} next cycle; later memory tag 5 produces no push and clears entry 5. Feature off: only the memory data is pushed.
- Same-cycle c2c push and memory return for tag 2 (id 1, 0xAA) -> FIFO order is c2c first, then {1, 0xAA}; count += 2.
- Fill to RSPQ_DEPTH-2 -> rspq_stall_o=1. A pop with no push in that cycle drops count to RSPQ_DEPTH-3 and stall deasserts the following cycle.
- Errors: memory tag 7 with no entry -> rspq_err_o=1, no push; allocating valid tag 3 again -> rspq_err_o=1; both stay set until reset.
- Reset mid-stream: 3 entries queued plus 2 pending tags, drive rst=0 for one edge -> vld=0, stall=0, err=0. A later return of an old tag sets err and pushes nothing.
